piso_serializer: RTL and testbench
==================================

# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, per-word selectable bit order, and a one-entry holding register so consecutive words stream with no idle gap. It is the next-generation replacement for the fixed 4-bit PISO shift register. It sits between a word-oriented producer and a bit-serial line driver, and emits one bit per clock with frame-boundary markers.

## Interface
Parameters:
- WIDTH, 8, bits per word; legal range is 2 or more
- IDLE_LEVEL, 1'b0, value driven on serial_out when no bit is valid

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- load_data  input  WIDTH  parallel word to serialize
- load_dir  input  1  bit order for this word: 0 = MSB first, 1 = LSB first
- load_valid  input  1  producer offers load_data/load_dir
- load_ready  output  1  block can accept a word this cycle
- serial_out  output  1  current serial bit
- ser_valid  output  1  serial_out carries a data bit
- ser_first  output  1  serial_out is bit 0 of a word
- ser_last  output  1  serial_out is the final bit of a word
- busy  output  1  shift register or holding register occupied

## Operation
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset values:
  - serial_out = IDLE_LEVEL.
  - ser_valid, ser_first, ser_last and busy = 0.
  - load_ready = 1.
  - State = IDLE, holding register empty, bit counter = 0.
- Handshake:
  - A word is accepted on a rising edge where load_valid and load_ready are both 1.
  - load_ready = !hold_full, combinational from a register only.
  - The producer must hold load_data and load_dir stable while load_valid = 1 and load_ready = 0.
- Bit order: load_dir is latched with the word. Changing load_dir later has no effect on a word already accepted.
- State IDLE:
  - An accepted word goes directly into the shift register.
  - The block moves to SHIFT and the bit counter is set to 0.
- State SHIFT:
  - Each edge advances one bit and increments the counter.
  - The edge where the counter is WIDTH-1 (the last bit) ends the current word, then one of:
    - Holding register full: its word moves to the shift register, the holding register empties, and the state stays SHIFT.
    - Holding register empty and a word is accepted on that same edge: the accepted word goes directly to the shift register, and the state stays SHIFT.
    - Otherwise: the state moves to IDLE.
  - A word accepted on any non-last edge goes to the holding register.
- Output mapping:
  - MSB first: bits go out in the order word[WIDTH-1] down to word[0].
  - LSB first: bits go out in the order word[0] up to word[WIDTH-1].
  - ser_first = SHIFT and counter == 0.
  - ser_last = SHIFT and counter == WIDTH-1.
  - busy = SHIFT or hold_full.
- serial_out is registered and is never X. It equals IDLE_LEVEL whenever ser_valid = 0.
- Counter width is $clog2(WIDTH). The counter wraps to 0 only through the reload path.
- If reset_n is asserted mid-word, the in-flight word and the held word are discarded. Outputs return to their reset values immediately, without waiting for a clock edge.

## Timing
- Latency: a word accepted at edge k in IDLE puts its first bit on serial_out after edge k, with ser_valid = ser_first = 1.
- A word occupies exactly WIDTH consecutive cycles.
- Back-to-back words: ser_last of word n is followed on the next cycle by ser_first of word n+1, with zero gap, whenever word n+1 is held or accepted on word n's last edge.
- Sustained throughput is one bit per clock.
- load_ready falls the cycle after the holding register fills. It rises the cycle after the holding register drains.

## Structure
- Package piso_pkg contains:
  - the state enum: ST_IDLE, ST_SHIFT
  - the direction constants: DIR_MSB_FIRST = 1'b0, DIR_LSB_FIRST = 1'b1
- Sub-module piso_hold_buffer: a one-entry register that stores data and dir. It has write-enable, read-enable and full-flag ports.
- The top level contains the FSM, the shift register, the counter and the output decode.

## Test plan
All scenarios use WIDTH = 4 and IDLE_LEVEL = 0.
- Reset then a single word: load 4'b1011 with dir 0 → serial_out goes 1,0,1,1 on 4 consecutive cycles. ser_first is high on cycle 1 and ser_last on cycle 4. The following cycle shows ser_valid = 0, serial_out = 0, busy = 0.
- LSB first: load 4'b1101 with dir 1 → serial_out goes 1,0,1,1. Then load 4'b0001 with dir 1 → 1,0,0,0.
- Back-to-back with mixed order: load 4'b1011 (dir 0), then 4'b1101 (dir 1) while the first word is shifting → 8 contiguous valid bits 1,0,1,1,1,0,1,1 with no gap. ser_last of the first word is immediately followed by ser_first of the second.
- Backpressure: hold load_valid = 1 constantly with three words → load_ready drops after the second word is accepted. The third word is accepted only after the holding register drains. All 12 bits come out in order.
- Reset mid-word: assert reset_n low during bit 2 of 4'b1111 → serial_out = 0, ser_valid = 0 and load_ready = 1 with no clock edge required. After release, the next loaded word serializes cleanly.
- Direction change while loaded: accept 4'b1000 with dir 0, then toggle load_dir during the shift → output is still 1,0,0,0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_hold_buffer.sv
// One-entry holding register (word plus bit order) that lets the next word
// wait while the current one is still shifting out.
module piso_hold_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_dir_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_dir_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    full_d = full_q;
    if (rd_en_i) begin
      full_d = 1'b0;
    end
    if (wr_en_i) begin
      data_d = wr_data_i;
      dir_d  = wr_dir_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      dir_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      full_q <= full_d;
    end
  end

  assign rd_data_o = data_q;
  assign rd_dir_o  = dir_q;
  assign full_o    = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one bit per clock, per-word bit order,
// frame markers, and a holding register so consecutive words stream gap-free.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  // Handshake: a word transfers on a rising edge with load_valid && load_ready;
  // load_ready is simply "holding register empty" and never depends on load_valid.

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;

  logic             hold_wr, hold_rd, hold_full, hold_dir;
  logic [WIDTH-1:0] hold_data;
  logic             accept, last_bit;

  // Words are stored pre-ordered so the bit on the line is always the MSB.
  function automatic logic [WIDTH-1:0] order_word(input logic [WIDTH-1:0] d,
                                                  input logic dir);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = (dir == DIR_LSB_FIRST) ? d[WIDTH-1-i] : d[i];
    end
    return r;
  endfunction

  piso_hold_buffer #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (hold_wr),
    .wr_data_i (load_data),
    .wr_dir_i  (load_dir),
    .rd_en_i   (hold_rd),
    .rd_data_o (hold_data),
    .rd_dir_o  (hold_dir),
    .full_o    (hold_full)
  );

  assign accept   = load_valid && !hold_full;
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    hold_wr = 1'b0;
    hold_rd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = order_word(load_data, load_dir);
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          if (hold_full) begin
            shreg_d = order_word(hold_data, hold_dir);
            hold_rd = 1'b1;
          end else if (accept) begin
            shreg_d = order_word(load_data, load_dir);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shreg_d = shreg_q << 1;
          hold_wr = accept;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sout_d = (state_d == ST_SHIFT) ? shreg_d[WIDTH-1] : IDLE_LEVEL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sout_q  <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
    end
  end

  assign load_ready = !hold_full;
  assign serial_out = sout_q;
  assign ser_valid  = (state_q == ST_SHIFT);
  assign ser_first  = ser_valid && (cnt_q == '0);
  assign ser_last   = ser_valid && (cnt_q == CNT_LAST);
  assign busy       = ser_valid || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=4, IDLE_LEVEL=0).
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] load_data;
  logic         load_dir;
  logic         load_valid;
  logic         load_ready;
  logic         serial_out;
  logic         ser_valid;
  logic         ser_first;
  logic         ser_last;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries: {bit, first, last} in the order they must appear.
  logic [2:0]  exp_q[$];
  logic [2:0]  mon_e;
  logic [63:0] out_log = '0;
  int          out_n   = 0;
  int          runs    = 0;
  logic        prev_v  = 1'b0;

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_data  (load_data),
    .load_dir   (load_dir),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .serial_out (serial_out),
    .ser_valid  (ser_valid),
    .ser_first  (ser_first),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Emission sequence of a word, first emitted bit in the MSB position.
  function automatic logic [W-1:0] emit_order(input logic [W-1:0] d, input logic dir);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[W-1-i] = dir ? d[i] : d[W-1-i];
    end
    return r;
  endfunction

  task automatic push_word(input logic [W-1:0] d, input logic dir);
    logic [W-1:0] seq;
    seq = emit_order(d, dir);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back({seq[W-1-i], (i == 0), (i == W-1)});
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      if (ser_valid !== (exp_q.size() > 0)) begin
        failures++;
        $display("FAIL mon_ser_valid got=%b exp=%b", ser_valid, (exp_q.size() > 0));
      end
      checks++;
      if (busy !== (exp_q.size() > 0)) begin
        failures++;
        $display("FAIL mon_busy got=%b exp=%b", busy, (exp_q.size() > 0));
      end
      checks++;
      if (load_ready !== (exp_q.size() <= W)) begin
        failures++;
        $display("FAIL mon_load_ready got=%b exp=%b", load_ready, (exp_q.size() <= W));
      end
      if (ser_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_unexpected_bit got=%b exp=none", serial_out);
        end else begin
          mon_e = exp_q.pop_front();
          if ({serial_out, ser_first, ser_last} !== mon_e) begin
            failures++;
            $display("FAIL mon_bit {out,first,last} got=%b exp=%b",
                     {serial_out, ser_first, ser_last}, mon_e);
          end
        end
        out_log = {out_log[62:0], serial_out};
        out_n++;
        if (!prev_v) runs++;
      end else begin
        checks++;
        if ({serial_out, ser_first, ser_last} !== 3'b000) begin
          failures++;
          $display("FAIL mon_idle {out,first,last} got=%b exp=000",
                   {serial_out, ser_first, ser_last});
        end
      end
      prev_v = (ser_valid === 1'b1);
    end else begin
      prev_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_log();
    out_log = '0;
    out_n   = 0;
    runs    = 0;
  endtask

  // Starts and ends at a falling edge.
  task automatic send_word(input logic [W-1:0] d, input logic dir, input logic keep,
                           output int stalls);
    stalls     = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_dir   = dir;
    while (load_ready !== 1'b1 && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (load_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=stalled exp=accepted data=%h", d);
    end else begin
      @(posedge clk);
      push_word(d, dir);
      @(negedge clk);
    end
    if (!keep) load_valid = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (ser_valid === 1'b0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dir   = 1'b0;
    #1;
    checks++;
    if ({serial_out, ser_valid, ser_first, ser_last, busy, load_ready} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000001",
               {serial_out, ser_valid, ser_first, ser_last, busy, load_ready});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({serial_out, ser_valid, busy, load_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_release got=%b exp=0001", {serial_out, ser_valid, busy, load_ready});
    end
  endtask

  task automatic test_single_word();
    int   st;
    logic ok;
    clear_log();
    send_word(4'b1011, 1'b0, 1'b0, st);
    checks++;
    if ({ser_valid, ser_first, serial_out} !== 3'b111) begin
      failures++;
      $display("FAIL single_latency {valid,first,out} got=%b exp=111",
               {ser_valid, ser_first, serial_out});
    end
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL single_idle_timeout got=%b exp=1", ok);
    end
    checks++;
    if (out_n != W || out_log[3:0] !== 4'b1011) begin
      failures++;
      $display("FAIL single_bits got=%0d/%b exp=4/1011", out_n, out_log[3:0]);
    end
    checks++;
    if ({serial_out, ser_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL single_after got=%b exp=000", {serial_out, ser_valid, busy});
    end
  endtask

  task automatic test_lsb_first();
    int   st;
    logic ok;
    clear_log();
    send_word(4'b1101, 1'b1, 1'b0, st);
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || out_n != W || out_log[3:0] !== 4'b1011) begin
      failures++;
      $display("FAIL lsb_word1 got=%0d/%b exp=4/1011", out_n, out_log[3:0]);
    end
    clear_log();
    send_word(4'b0001, 1'b1, 1'b0, st);
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || out_n != W || out_log[3:0] !== 4'b1000) begin
      failures++;
      $display("FAIL lsb_word2 got=%0d/%b exp=4/1000", out_n, out_log[3:0]);
    end
  endtask

  task automatic test_back_to_back();
    int   s0, s1;
    logic ok;
    clear_log();
    send_word(4'b1011, 1'b0, 1'b1, s0);
    send_word(4'b1101, 1'b1, 1'b0, s1);
    checks++;
    if (s1 != 0) begin
      failures++;
      $display("FAIL b2b_stall got=%0d exp=0", s1);
    end
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || out_n != 2*W || runs != 1 || out_log[7:0] !== 8'b10111011) begin
      failures++;
      $display("FAIL b2b_stream got=n%0d runs%0d %b exp=n8 runs1 10111011",
               out_n, runs, out_log[7:0]);
    end
  endtask

  task automatic test_last_edge_accept();
    int           st;
    logic         ok;
    logic [W-1:0] a, b;
    logic         da, db;
    a  = W'($urandom_range(0, 15));
    b  = W'($urandom_range(0, 15));
    da = 1'($urandom_range(0, 1));
    db = 1'($urandom_range(0, 1));
    clear_log();
    send_word(a, da, 1'b0, st);
    repeat (W-1) @(negedge clk);
    checks++;
    if (ser_last !== 1'b1) begin
      failures++;
      $display("FAIL lastedge_marker got=%b exp=1", ser_last);
    end
    send_word(b, db, 1'b0, st);
    checks++;
    if ({ser_valid, ser_first, st == 0} !== 3'b111) begin
      failures++;
      $display("FAIL lastedge_next_first {valid,first,nostall} got=%b exp=111",
               {ser_valid, ser_first, st == 0});
    end
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || runs != 1 || out_n != 2*W ||
        out_log[7:0] !== {emit_order(a, da), emit_order(b, db)}) begin
      failures++;
      $display("FAIL lastedge_stream got=runs%0d %b exp=runs1 %b", runs, out_log[7:0],
               {emit_order(a, da), emit_order(b, db)});
    end
  endtask

  task automatic test_backpressure();
    int           s0, s1, s2;
    logic         ok;
    logic [W-1:0] a, b, c;
    logic         da, db, dc;
    a = W'($urandom_range(0, 15)); da = 1'($urandom_range(0, 1));
    b = W'($urandom_range(0, 15)); db = 1'($urandom_range(0, 1));
    c = W'($urandom_range(0, 15)); dc = 1'($urandom_range(0, 1));
    clear_log();
    send_word(a, da, 1'b1, s0);
    send_word(b, db, 1'b1, s1);
    checks++;
    if (load_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_drop got=%b exp=0", load_ready);
    end
    send_word(c, dc, 1'b0, s2);
    checks++;
    if (s1 != 0 || s2 != W-1) begin
      failures++;
      $display("FAIL bp_stalls got=%0d,%0d exp=0,%0d", s1, s2, W-1);
    end
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || runs != 1 || out_n != 3*W ||
        out_log[11:0] !== {emit_order(a, da), emit_order(b, db), emit_order(c, dc)}) begin
      failures++;
      $display("FAIL bp_stream got=runs%0d n%0d %b exp=runs1 n12 %b", runs, out_n,
               out_log[11:0], {emit_order(a, da), emit_order(b, db), emit_order(c, dc)});
    end
  endtask

  task automatic test_reset_mid_word();
    int           st;
    logic         ok;
    logic [W-1:0] d;
    logic         dd;
    send_word(4'b1111, 1'b0, 1'b1, st);
    send_word(W'($urandom_range(0, 15)), 1'b0, 1'b0, st);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({serial_out, ser_valid, ser_first, ser_last, busy, load_ready} !== 6'b000001) begin
      failures++;
      $display("FAIL midreset_async got=%b exp=000001",
               {serial_out, ser_valid, ser_first, ser_last, busy, load_ready});
    end
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    d  = W'($urandom_range(0, 15));
    dd = 1'($urandom_range(0, 1));
    clear_log();
    send_word(d, dd, 1'b0, st);
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || out_n != W || out_log[3:0] !== emit_order(d, dd)) begin
      failures++;
      $display("FAIL midreset_recover got=%0d/%b exp=4/%b", out_n, out_log[3:0],
               emit_order(d, dd));
    end
  endtask

  task automatic test_dir_change();
    int   st;
    logic ok;
    clear_log();
    send_word(4'b1000, 1'b0, 1'b0, st);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load_dir = ~load_dir;
    end
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || out_n != W || out_log[3:0] !== 4'b1000) begin
      failures++;
      $display("FAIL dirchange_bits got=%0d/%b exp=4/1000", out_n, out_log[3:0]);
    end
  endtask

  task automatic test_random();
    int   st;
    logic ok;
    logic keep;
    clear_log();
    for (int n = 0; n < 60; n++) begin
      keep = (n == 59) ? 1'b0 : 1'($urandom_range(0, 1));
      send_word(W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), keep, st);
      if (!keep) repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || exp_q.size() != 0 || out_n != 60*W) begin
      failures++;
      $display("FAIL random_drain got=ok%b left%0d n%0d exp=ok1 left0 n%0d",
               ok, exp_q.size(), out_n, 60*W);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_lsb_first();
    test_back_to_back();
    test_last_edge_accept();
    test_backpressure();
    test_reset_mid_word();
    test_dir_change();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
